// File: rtl/ll_link_online_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ll_link_online_ctrl_if
// Brief    : Link status/online bundle between PHY-side status and the online
//            sequencer. The sequencer takes the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface ll_link_online_ctrl_if #(
    parameter int NUM_CH = 2
);
    logic              link_enable;
    logic [NUM_CH-1:0] chan_xfer_en;
    logic              chan_align_done;
    logic              rx_fifo_empty;
    logic              tx_online;
    logic              rx_online;

    modport master (
        output link_enable,
        output chan_xfer_en,
        output chan_align_done,
        output rx_fifo_empty,
        input  tx_online,
        input  rx_online
    );

    modport slave (
        input  link_enable,
        input  chan_xfer_en,
        input  chan_align_done,
        input  rx_fifo_empty,
        output tx_online,
        output rx_online
    );
endinterface
`default_nettype wire

// File: rtl/ll_link_online_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ll_link_online_ctrl
// Brief    : Logic-link bring-up/teardown sequencer driving tx/rx online.
// Revision : 1.0 - initial release
// ============================================================================
module ll_link_online_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int HOLDOFF_CYC = 16
) (
    input  wire logic               clk_wr,
    input  wire logic               rst_wr,
    ll_link_online_ctrl_if.slave    link,
    input  wire logic [15:0]        settle_value,
    input  wire logic [15:0]        timeout_value,
    input  wire logic               err_clr,
    output logic      [2:0]         link_state,
    output logic                    align_timeout_err,
    output logic      [7:0]         retrain_count
);

    localparam logic [2:0] c_st_disabled   = 3'd0;
    localparam logic [2:0] c_st_wait_xfer  = 3'd1;
    localparam logic [2:0] c_st_wait_align = 3'd2;
    localparam logic [2:0] c_st_settle     = 3'd3;
    localparam logic [2:0] c_st_online     = 3'd4;
    localparam logic [2:0] c_st_drain      = 3'd5;
    localparam logic [2:0] c_st_holdoff    = 3'd6;

    localparam logic [15:0] c_holdoff_last = 16'(HOLDOFF_CYC - 1);

    logic [NUM_CH-1:0] w_xfer_en;
    logic              w_all_en;
    logic              w_go_offline;
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [15:0]       r_cnt;
    logic              w_timeout_hit;
    logic              w_retrain_inc;
    logic              w_cnt_run;
    logic              w_tx_nxt;
    logic              w_rx_nxt;
    logic              r_tx_online;
    logic              r_rx_online;

    assign w_xfer_en    = link.chan_xfer_en;
    assign w_all_en     = &w_xfer_en;
    assign w_go_offline = !link.link_enable || !w_all_en || !link.chan_align_done;

    // State register with registered online outputs
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_state     <= c_st_disabled;
            r_tx_online <= 1'b0;
            r_rx_online <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_online <= w_tx_nxt;
            r_rx_online <= w_rx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        w_retrain_inc = 1'b0;
        case (r_state)
            c_st_disabled: begin
                if (link.link_enable) w_state_nxt = c_st_wait_xfer;
            end
            c_st_wait_xfer: begin
                if (!link.link_enable) w_state_nxt = c_st_disabled;
                else if (w_all_en)     w_state_nxt = c_st_wait_align;
            end
            c_st_wait_align: begin
                if (!link.link_enable || !w_all_en) begin
                    w_state_nxt = c_st_wait_xfer;
                end else if (link.chan_align_done) begin
                    w_state_nxt = c_st_settle;
                end else if ((timeout_value != 16'd0) &&
                             (r_cnt == 16'(timeout_value - 16'd1))) begin
                    w_state_nxt   = c_st_holdoff;
                    w_timeout_hit = 1'b1;
                end
            end
            c_st_settle: begin
                if (w_go_offline)               w_state_nxt = c_st_wait_xfer;
                else if (r_cnt >= settle_value) w_state_nxt = c_st_online;
            end
            c_st_online: begin
                if (w_go_offline) begin
                    w_state_nxt = c_st_drain;
                    // A pure software disable is not a link fault
                    w_retrain_inc = !w_all_en || !link.chan_align_done;
                end
            end
            c_st_drain: begin
                if (link.rx_fifo_empty) w_state_nxt = c_st_holdoff;
            end
            c_st_holdoff: begin
                if (r_cnt == c_holdoff_last) begin
                    w_state_nxt = link.link_enable ? c_st_wait_xfer : c_st_disabled;
                end
            end
            default: w_state_nxt = c_st_disabled;
        endcase
    end

    // Output logic, decoded from the state about to be registered
    always_comb begin
        w_tx_nxt = (w_state_nxt == c_st_online);
        w_rx_nxt = (w_state_nxt == c_st_online) || (w_state_nxt == c_st_drain);
    end

    assign w_cnt_run = (w_state_nxt == r_state) &&
                       ((r_state == c_st_wait_align) || (r_state == c_st_settle) ||
                        (r_state == c_st_holdoff));

    // Counter clears on any state change and saturates rather than wrapping
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_cnt <= 16'd0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= 16'd0;
        end else if (w_cnt_run && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Sticky error (set beats clear) and saturating retrain counter
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            align_timeout_err <= 1'b0;
            retrain_count     <= 8'd0;
        end else begin
            if (w_timeout_hit)  align_timeout_err <= 1'b1;
            else if (err_clr)   align_timeout_err <= 1'b0;
            if (w_retrain_inc && (retrain_count != 8'hFF)) begin
                retrain_count <= retrain_count + 8'd1;
            end
        end
    end

    assign link_state     = r_state;
    assign link.tx_online = r_tx_online;
    assign link.rx_online = r_rx_online;

endmodule
`default_nettype wire

// File: tb/tb_ll_link_online_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ll_link_online_ctrl
// Brief    : Directed self-checking bench for ll_link_online_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ll_link_online_ctrl;

    logic        clk_wr;
    logic        rst_wr;
    logic [15:0] settle_value;
    logic [15:0] timeout_value;
    logic        err_clr;
    logic [2:0]  link_state;
    logic        align_timeout_err;
    logic [7:0]  retrain_count;

    int r_checks;
    int r_errors;

    ll_link_online_ctrl_if #(.NUM_CH(2)) link_if ();

    ll_link_online_ctrl #(
        .NUM_CH      (2),
        .HOLDOFF_CYC (16)
    ) u_dut (
        .clk_wr            (clk_wr),
        .rst_wr            (rst_wr),
        .link              (link_if.slave),
        .settle_value      (settle_value),
        .timeout_value     (timeout_value),
        .err_clr           (err_clr),
        .link_state        (link_state),
        .align_timeout_err (align_timeout_err),
        .retrain_count     (retrain_count)
    );

    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        r_checks++;
        if (obs !== exp_val) begin
            r_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
        end
    endtask

    // Advance n rising edges; leaves time 1 unit after the last edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk_wr);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic tx,
                           input logic rx);
        chk({tag, "_state"}, 32'(link_state), 32'(st));
        chk({tag, "_tx"},    32'(link_if.tx_online), 32'(tx));
        chk({tag, "_rx"},    32'(link_if.rx_online), 32'(rx));
    endtask

    initial begin
        r_checks = 0;
        r_errors = 0;
        rst_wr                  = 1'b1;
        link_if.link_enable     = 1'b0;
        link_if.chan_xfer_en    = 2'b00;
        link_if.chan_align_done = 1'b0;
        link_if.rx_fifo_empty   = 1'b1;
        settle_value            = 16'd8;
        timeout_value           = 16'd0;
        err_clr                 = 1'b0;
        tick(2);
        rst_wr = 1'b0;
        chk_all("reset", 3'd0, 1'b0, 1'b0);
        chk("reset_err", 32'(align_timeout_err), 32'd0);
        chk("reset_rc", 32'(retrain_count), 32'd0);

        // Bring-up with settle_value=8
        link_if.link_enable = 1'b1;
        tick(1); chk_all("up_wx", 3'd1, 1'b0, 1'b0);
        link_if.chan_xfer_en = 2'b11;
        tick(1); chk_all("up_wa", 3'd2, 1'b0, 1'b0);
        link_if.chan_align_done = 1'b1;
        tick(1); chk_all("up_settle0", 3'd3, 1'b0, 1'b0);
        tick(8); chk_all("up_settle8", 3'd3, 1'b0, 1'b0);
        tick(1); chk_all("up_online", 3'd4, 1'b1, 1'b1);

        // Alignment loss with a 7-cycle RX backlog
        link_if.rx_fifo_empty   = 1'b0;
        link_if.chan_align_done = 1'b0;
        tick(1); chk_all("loss_drain1", 3'd5, 1'b0, 1'b1);
        chk("loss_rc", 32'(retrain_count), 32'd1);
        tick(6); chk_all("loss_drain7", 3'd5, 1'b0, 1'b1);
        link_if.rx_fifo_empty = 1'b1;
        tick(1); chk_all("loss_holdoff", 3'd6, 1'b0, 1'b0);
        tick(15); chk_all("loss_holdoff16", 3'd6, 1'b0, 1'b0);
        tick(1); chk_all("loss_rearm", 3'd1, 1'b0, 1'b0);
        tick(1); chk_all("loss_wa", 3'd2, 1'b0, 1'b0);

        // settle_value=0: online two edges after align is sampled
        settle_value = 16'd0;
        link_if.chan_align_done = 1'b1;
        tick(1); chk_all("s0_settle", 3'd3, 1'b0, 1'b0);
        tick(1); chk_all("s0_online", 3'd4, 1'b1, 1'b1);

        // Software disable with empty FIFO does not count as a retrain
        link_if.link_enable = 1'b0;
        tick(1); chk_all("dis_drain", 3'd5, 1'b0, 1'b1);
        chk("dis_rc", 32'(retrain_count), 32'd1);
        tick(1); chk_all("dis_holdoff", 3'd6, 1'b0, 1'b0);
        tick(15); chk_all("dis_holdoff16", 3'd6, 1'b0, 1'b0);
        tick(1); chk_all("dis_disabled", 3'd0, 1'b0, 1'b0);
        chk("dis_rc_end", 32'(retrain_count), 32'd1);

        // Alignment timeout of 50 cycles
        timeout_value           = 16'd50;
        link_if.chan_align_done = 1'b0;
        link_if.link_enable     = 1'b1;
        tick(1); chk("to_wx", 32'(link_state), 32'd1);
        tick(1); chk("to_wa", 32'(link_state), 32'd2);
        tick(49); chk("to_wa49", 32'(link_state), 32'd2);
        chk("to_err_before", 32'(align_timeout_err), 32'd0);
        tick(1); chk("to_holdoff", 32'(link_state), 32'd6);
        chk("to_err_set", 32'(align_timeout_err), 32'd1);
        tick(15); chk("to_holdoff16", 32'(link_state), 32'd6);
        tick(1); chk("to_rearm", 32'(link_state), 32'd1);
        chk("to_err_sticky", 32'(align_timeout_err), 32'd1);
        err_clr = 1'b1;
        tick(1); chk("to_err_clr", 32'(align_timeout_err), 32'd0);
        chk("to_wa_again", 32'(link_state), 32'd2);
        err_clr       = 1'b0;
        timeout_value = 16'd0;

        // Partial transfer enable parks in WAIT_XFER
        link_if.chan_xfer_en = 2'b01;
        tick(1); chk("part_wx", 32'(link_state), 32'd1);
        tick(20); chk("part_wx20", 32'(link_state), 32'd1);

        // 258 fault cycles saturate the retrain counter
        link_if.chan_xfer_en    = 2'b11;
        link_if.chan_align_done = 1'b1;
        for (int i = 0; i < 258; i++) begin
            tick(3);
            if (i == 0) chk_all("sat_online0", 3'd4, 1'b1, 1'b1);
            link_if.chan_align_done = 1'b0;
            tick(18);
            if (i == 9) chk("sat_rc10", 32'(retrain_count), 32'd11);
            link_if.chan_align_done = 1'b1;
        end
        chk("sat_rc", 32'(retrain_count), 32'd255);
        chk("sat_state", 32'(link_state), 32'd1);

        // Reset while ONLINE drops everything without draining
        tick(3); chk_all("rst_online", 3'd4, 1'b1, 1'b1);
        rst_wr = 1'b1;
        tick(1); chk_all("rst_hit", 3'd0, 1'b0, 1'b0);
        chk("rst_rc", 32'(retrain_count), 32'd0);
        chk("rst_err", 32'(align_timeout_err), 32'd0);
        rst_wr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ll_link_online_ctrl.md
Name: ll_link_online_ctrl

Overview:
- Link bring-up and teardown sequencer for one logic-link instance (for example a 2-channel asymmetric AXI-ST slave).
- Watches per-channel transfer-enable and channel-alignment status, waits a programmable settle time, then drives the tx_online and rx_online inputs of the auto-sync and logic-link blocks.
- On disable or loss of alignment it quiesces the link in order: stop TX, drain the RX FIFO, drop RX, then hold off before retraining.

Parameters:
- NUM_CH, 2, number of PHY channels monitored.
- HOLDOFF_CYC, 16, cycles spent in HOLDOFF before re-arming (must be ≥1).

Ports:
- clk_wr  input  1  link clock; all logic on its rising edge.
- rst_wr  input  1  synchronous reset, active-high.
- link_enable  input  1  software enable; level-sensitive.
- chan_xfer_en  input  NUM_CH  per-channel PHY transfer-enable.
- chan_align_done  input  1  multi-channel alignment complete.
- settle_value  input  16  cycles spent in SETTLE before going online.
- timeout_value  input  16  WAIT_ALIGN timeout in cycles; 0 disables the timeout.
- rx_fifo_empty  input  1  logic-link RX FIFO empty (no user valid pending).
- err_clr  input  1  single-cycle pulse that clears the sticky error.
- tx_online  output  1  to the auto-sync/logic-link TX online input.
- rx_online  output  1  to the auto-sync/logic-link RX online input.
- link_state  output  3  current FSM state encoding.
- align_timeout_err  output  1  sticky alignment-timeout flag.
- retrain_count  output  8  count of ONLINE→fault exits; saturates at 255.

Behaviour:
- Reset (rst_wr high at a clock edge): state=DISABLED(0); tx_online=0; rx_online=0; align_timeout_err=0; retrain_count=0; counter=0.
- all_en = AND of chan_xfer_en.
- "Go offline" condition: !link_enable or !all_en or !chan_align_done.
- All outputs are registered and are pure functions of the registered state:
  - tx_online=1 only in ONLINE.
  - rx_online=1 in ONLINE and DRAIN.
- States and transitions (evaluated every cycle; first matching rule wins):
  - DISABLED(0): link_enable → WAIT_XFER.
  - WAIT_XFER(1):
    - !link_enable → DISABLED.
    - all_en → WAIT_ALIGN; counter cleared.
  - WAIT_ALIGN(2):
    - !link_enable or !all_en → WAIT_XFER.
    - chan_align_done → SETTLE; counter cleared.
    - timeout_value≠0 and counter==timeout_value-1 → set align_timeout_err, go to HOLDOFF.
    - Otherwise counter increments.
  - SETTLE(3):
    - Go-offline condition → WAIT_XFER.
    - counter≥settle_value → ONLINE.
    - Otherwise counter increments.
    - settle_value=0 reaches ONLINE on the next cycle, so SETTLE lasts exactly settle_value+1 cycles.
  - ONLINE(4): go-offline condition → DRAIN; retrain_count increments (saturating) unless the cause is !link_enable alone.
  - DRAIN(5): rx_fifo_empty → HOLDOFF, counter cleared. There is no timeout: drain completes only via the FIFO or reset.
  - HOLDOFF(6): counter==HOLDOFF_CYC-1 → DISABLED if !link_enable, else WAIT_XFER. Otherwise counter increments.
  - Encoding 7 is illegal and recovers to DISABLED on the next cycle.
- Latency:
  - chan_align_done rising in WAIT_ALIGN → tx_online/rx_online high exactly settle_value+2 cycles later.
  - Fault in ONLINE → tx_online low the next cycle. rx_online stays high until the cycle after rx_fifo_empty is sampled high in DRAIN.
- Counter: 16-bit, never wraps. It is cleared on every state entry and held at its value outside counting states.
- align_timeout_err clearing:
  - Cleared by err_clr.
  - If err_clr and a new timeout occur in the same cycle, set wins.
  - Reset clears it.
- Inputs changing in the same cycle as a transition: only the current-cycle sampled values are used; there is no input pipelining.
- Reset mid-operation (for example in ONLINE) drops both online outputs the next cycle without draining. Upstream tolerates this because the logic-link blocks share the same reset.

Test Plan:
- Bring-up: link_enable=1, chan_xfer_en=2'b11 at cycle 5, chan_align_done at cycle 10, settle_value=8 → tx_online/rx_online rise at cycle 20; link_state sequence 1,2,3,4.
- Timeout: timeout_value=50, align never asserts → align_timeout_err=1 at 50 cycles after WAIT_ALIGN entry; HOLDOFF for 16 cycles; back to WAIT_XFER; err_clr pulse → flag 0.
- Align loss with backlog: in ONLINE, drop chan_align_done while rx_fifo_empty=0 for 7 cycles → tx_online low next cycle; rx_online stays high 7 cycles, then low; retrain_count=1.
- Disable: link_enable=0 in ONLINE with FIFO empty → DRAIN for 1 cycle, HOLDOFF 16 cycles, then DISABLED; retrain_count unchanged.
- Boundary: settle_value=0 gives online 2 cycles after align. Forcing 255+3 faults leaves retrain_count=255. chan_xfer_en=2'b01 holds in WAIT_XFER indefinitely.
- Reset in ONLINE: rst_wr asserted for 1 cycle → all outputs 0 and state 0 on the next edge; no DRAIN visited.
